// File: rtl/player_state.sv
// Player position, aim and single-projectile state for one side of the game.
// Moves and aim steps are accepted only while no shot is in flight.
module player_state (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       left_x,
    input  logic       right_x,
    input  logic       left_aim,
    input  logic       right_aim,
    input  logic       shoot_out,
    input  logic [4:0] select,
    input  logic       frame_tick,
    output logic [5:0] pos_x,
    output logic [2:0] aim,
    output logic       shot_active,
    output logic [5:0] shot_x,
    output logic [4:0] shot_y,
    output logic       shot_done,
    output logic       landed,
    output logic       round_start
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_LAND   = 2'd2,
        ST_MISS   = 2'd3
    } state_t;

    localparam logic [5:0] POS_MAX   = 6'd47;
    localparam logic [5:0] POS_START = 6'd24;
    localparam logic [2:0] AIM_MAX   = 3'd6;
    localparam logic [2:0] AIM_START = 3'd3;

    state_t     state_q, state_d;
    logic [5:0] pos_x_q, pos_x_d;
    logic [2:0] aim_q, aim_d;
    logic       shot_active_q, shot_active_d;
    logic [5:0] shot_x_q, shot_x_d;
    logic [4:0] shot_y_q, shot_y_d;
    logic [3:0] dx_q, dx_d;
    logic       shot_done_q, shot_done_d;
    logic       landed_q, landed_d;
    logic       round_start_q, round_start_d;
    logic [6:0] nx_s;

    // Saturating +/-1 step; simultaneous opposite pulses cancel.
    function automatic logic [5:0] step_pos(input logic [5:0] p, input logic dec, input logic inc);
        logic [5:0] r;
        if (dec && !inc && (p != 6'd0)) begin
            r = p - 6'd1;
        end else if (inc && !dec && (p != POS_MAX)) begin
            r = p + 6'd1;
        end else begin
            r = p;
        end
        return r;
    endfunction

    function automatic logic [2:0] step_aim(input logic [2:0] a, input logic dec, input logic inc);
        logic [2:0] r;
        if (dec && !inc && (a != 3'd0)) begin
            r = a - 3'd1;
        end else if (inc && !dec && (a != AIM_MAX)) begin
            r = a + 3'd1;
        end else begin
            r = a;
        end
        return r;
    endfunction

    // Candidate column: 7-bit sum goes negative (bit 6 set) when the shot leaves on the left.
    assign nx_s = {1'b0, shot_x_q} + {{3{dx_q[3]}}, dx_q};

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        pos_x_d       = pos_x_q;
        aim_d         = aim_q;
        shot_active_d = shot_active_q;
        shot_x_d      = shot_x_q;
        shot_y_d      = shot_y_q;
        dx_d          = dx_q;
        landed_d      = landed_q;
        shot_done_d   = 1'b0;
        round_start_d = 1'b0;
        if (!ena) begin
            shot_done_d   = 1'b0;
            round_start_d = 1'b0;
        end else begin
            round_start_d = select[1];
            if (select[2]) begin
                state_d       = ST_IDLE;
                pos_x_d       = POS_START;
                aim_d         = AIM_START;
                shot_x_d      = 6'd0;
                shot_y_d      = 5'd0;
                shot_active_d = 1'b0;
                dx_d          = 4'd0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (shoot_out) begin
                            state_d       = ST_FLIGHT;
                            shot_x_d      = pos_x_q;
                            shot_y_d      = 5'd0;
                            shot_active_d = 1'b1;
                            dx_d          = {1'b0, aim_q} - 4'd3;
                        end else begin
                            state_d = ST_IDLE;
                        end
                        if (select[4]) begin
                            pos_x_d = step_pos(pos_x_q, left_x, right_x);
                        end else begin
                            pos_x_d = pos_x_q;
                        end
                        if (select[3]) begin
                            aim_d = step_aim(aim_q, left_aim, right_aim);
                        end else begin
                            aim_d = aim_q;
                        end
                    end
                    ST_FLIGHT: begin
                        if (!frame_tick) begin
                            state_d = ST_FLIGHT;
                        end else if (nx_s[6] || (nx_s > {1'b0, POS_MAX})) begin
                            state_d       = ST_MISS;
                            shot_active_d = 1'b0;
                            shot_done_d   = 1'b1;
                            landed_d      = 1'b0;
                        end else begin
                            shot_x_d = nx_s[5:0];
                            shot_y_d = shot_y_q + 5'd1;
                            if (shot_y_q == 5'd30) begin
                                state_d       = ST_LAND;
                                shot_active_d = 1'b0;
                                shot_done_d   = 1'b1;
                                landed_d      = 1'b1;
                            end else begin
                                state_d = ST_FLIGHT;
                            end
                        end
                    end
                    ST_LAND, ST_MISS: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d       = ST_IDLE;
                        shot_active_d = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            pos_x_q       <= POS_START;
            aim_q         <= AIM_START;
            shot_active_q <= 1'b0;
            shot_x_q      <= 6'd0;
            shot_y_q      <= 5'd0;
            dx_q          <= 4'd0;
            shot_done_q   <= 1'b0;
            landed_q      <= 1'b0;
            round_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pos_x_q       <= pos_x_d;
            aim_q         <= aim_d;
            shot_active_q <= shot_active_d;
            shot_x_q      <= shot_x_d;
            shot_y_q      <= shot_y_d;
            dx_q          <= dx_d;
            shot_done_q   <= shot_done_d;
            landed_q      <= landed_d;
            round_start_q <= round_start_d;
        end
    end

    assign pos_x       = pos_x_q;
    assign aim         = aim_q;
    assign shot_active = shot_active_q;
    assign shot_x      = shot_x_q;
    assign shot_y      = shot_y_q;
    assign shot_done   = shot_done_q;
    assign landed      = landed_q;
    assign round_start = round_start_q;

endmodule

// File: doc/player_state.md
PLAYER_STATE -- requirements
Module: player_state

Interface
REQ-001 SHALL provide ports: clk  in  1  system clock, rising-edge active.
REQ-002 SHALL provide ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide ports: ena  in  1  global enable; low freezes all state.
REQ-004 SHALL provide ports: left_x, right_x  in  1 each  one-cycle move pulses from the input-control stage.
REQ-005 SHALL provide ports: left_aim, right_aim  in  1 each  one-cycle aim pulses.
REQ-006 SHALL provide ports: shoot_out  in  1  one-cycle fire pulse.
REQ-007 SHALL provide ports: select  in  5  one-hot command class {move, aim, new_game, new_game_delayed, none}, bit4..bit1.
REQ-008 SHALL provide ports: frame_tick  in  1  one-cycle projectile step strobe.
REQ-009 SHALL provide ports: pos_x  out  6  player column, 0..47.
REQ-010 SHALL provide ports: aim  out  3  aim index, 0..6, 3 = vertical.
REQ-011 SHALL provide ports: shot_active  out  1  projectile in flight.
REQ-012 SHALL provide ports: shot_x  out  6, shot_y  out  5  projectile position.
REQ-013 SHALL provide ports: shot_done  out  1  one-cycle end-of-shot pulse; landed  out  1  valid with shot_done, 1 = landed, 0 = left field.
REQ-014 SHALL provide ports: round_start  out  1  one-cycle pulse.

Function
REQ-015 SHALL implement FSM states IDLE, FLIGHT, LAND, MISS; all outputs registered.
REQ-016 SHALL, in IDLE with select[4]=1, apply left_x as pos_x-1, saturating at 0, and right_x as pos_x+1, saturating at 47; both pulses in one cycle -> no change.
REQ-017 SHALL, in IDLE with select[3]=1, apply left_aim as aim-1, saturating at 0, and right_aim as aim+1, saturating at 6; both in one cycle -> no change.
REQ-018 SHALL ignore move and aim pulses outside IDLE or when the matching select bit is 0.
REQ-019 SHALL, on shoot_out in IDLE, go to FLIGHT next cycle: shot_x=pos_x, shot_y=0, shot_active=1, latch signed step dx=aim-3 (range -3..+3, 4-bit two's complement).
REQ-020 SHALL ignore shoot_out when not in IDLE; it SHALL NOT queue.
REQ-021 SHALL, in FLIGHT on frame_tick, compute nx=shot_x+dx in 7-bit signed: nx<0 or nx>47 -> MISS, shot_x/shot_y held; else shot_x=nx, shot_y=shot_y+1.
REQ-022 SHALL, when the increment in REQ-021 makes shot_y=31, go to LAND; an out-of-field result SHALL take priority over LAND.
REQ-023 SHALL hold FLIGHT without change when frame_tick=0.
REQ-024 SHALL spend exactly one cycle in LAND or MISS: shot_done=1, landed=1 (LAND) or 0 (MISS), shot_active=0; then go to IDLE.
REQ-025 SHALL treat select[2]=1 as synchronous new game, highest priority over every other input in every state: pos_x=24, aim=3, shot_x=0, shot_y=0, shot_active=0, state=IDLE; no shot_done pulse for an aborted shot.
REQ-026 SHALL pulse round_start for one cycle on the cycle following select[1]=1.
REQ-027 SHALL, with ena=0, hold every register and drive shot_done=0 and round_start=0; pulses arriving while ena=0 are lost.

Reset
REQ-028 SHALL, while reset=0, asynchronously force pos_x=24, aim=3, shot_x=0, shot_y=0, shot_active=0, shot_done=0, landed=0, round_start=0, state=IDLE.
REQ-029 SHALL, when reset is asserted mid-flight, abort the shot with no shot_done; operation resumes on the first clk edge after release.

Verification
REQ-030 SHALL cover saturation: after reset, 30 right_x pulses with select=10000 -> pos_x=47; then 50 left_x pulses -> pos_x=0.
REQ-031 SHALL cover a vertical shot: aim=3, pos_x=10, shoot, 31 frame_ticks -> shot_x=10, shot_y=31, shot_done=1, landed=1 for one cycle, then IDLE.
REQ-032 SHALL cover a miss: pos_x=2, aim=0 (dx=-3), shoot, first frame_tick -> MISS, shot_done=1, landed=0, shot_x=2, shot_y=0.
REQ-033 SHALL cover busy input rejection: during FLIGHT, shoot_out, left_x and right_aim pulses -> pos_x, aim and shot state unchanged.
REQ-034 SHALL cover new game mid-flight: select=00100 in FLIGHT -> next cycle pos_x=24, aim=3, shot_active=0, no shot_done; select=00010 -> round_start pulse one cycle later.
REQ-035 SHALL cover freeze and reset: ena=0 with frame_tick pulses in FLIGHT -> shot_y unchanged; reset=0 asserted between edges -> outputs at reset values immediately.
